// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler
//   Round-robin phase scheduler for an N-phase intersection. One phase at a
//   time holds the right-of-way. Each grant runs through the sequence
//   GREEN -> YELLOW -> ALLRED, and then either re-grants or drops to IDLE.
//   Sensor requests are latched into a pending vector. Green timing enforces
//   min-green, max-green (applied only while another phase waits) and gap-out.
//
// Ports
//   clk        clock
//   reset      asynchronous, active-low reset
//   req        raw phase sensors, one bit per phase
//   green      green lamp per phase (one-hot or zero)
//   yellow     yellow lamp per phase (one-hot or zero)
//   cur_phase  phase currently or last served
//   busy       high in GREEN, YELLOW and ALLRED
//   pre_req    (TLC_PREEMPT_EN only) preemption request
//   pre_phase  (TLC_PREEMPT_EN only) phase the preemption wants served
//
// Build option
//   TLC_PREEMPT_EN : adds the preemption ports and behaviour. When it is left
//                    undefined, the scheduler is purely round-robin.
//
// The FSM state register is `state`, of type state_t. green, yellow and busy
// are registered. They are decoded from the next state and the next phase,
// so they always match state and cur_phase.
module tlc_phase_scheduler #(
  parameter int N_PHASES  = 5,
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 10,
  parameter int GAP       = 5,
  parameter int YELLOW    = 2,
  parameter int ALLRED    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PHASES-1:0]           req,
`ifdef TLC_PREEMPT_EN
  input  logic                          pre_req,
  input  logic [$clog2(N_PHASES)-1:0]   pre_phase,
`endif
  output logic [N_PHASES-1:0]           green,
  output logic [N_PHASES-1:0]           yellow,
  output logic [$clog2(N_PHASES)-1:0]   cur_phase,
  output logic                          busy
);

  localparam int PW   = $clog2(N_PHASES);
  localparam int M1   = (MAX_GREEN > GAP) ? MAX_GREEN : GAP;
  localparam int M2   = (YELLOW > ALLRED) ? YELLOW : ALLRED;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]       ONE_C = CW'(1);
  localparam logic [CW-1:0]       MIN_C = CW'(MIN_GREEN);
  localparam logic [CW-1:0]       MAX_C = CW'(MAX_GREEN);
  localparam logic [CW-1:0]       GAP_C = CW'(GAP);
  localparam logic [CW-1:0]       YEL_C = CW'(YELLOW);
  localparam logic [CW-1:0]       AR_C  = CW'(ALLRED);
  localparam logic [N_PHASES-1:0] ONE_N = N_PHASES'(1);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW_S, ALLRED_S} state_t;

  state_t              state, nstate;
  logic [N_PHASES-1:0] pending, cand, own_mask, set_mask, clr_mask, nmask;
  logic [CW-1:0]       green_ctr, gap_ctr, tmr;
  logic [PW-1:0]       win, gphase;
  logic                other, green_exit, grant;

  // This function returns the first set bit of c, searching from cur+1
  // upward with wrap-around. cur itself is visited last. The loop runs
  // backwards, so the closest hit in round-robin order is the last one
  // assigned.
  function automatic logic [PW-1:0] rr_pick(input logic [N_PHASES-1:0] c,
                                            input logic [PW-1:0] cur);
    logic [PW-1:0] pick;
    logic [PW-1:0] ii;
    pick = cur;
    for (int k = N_PHASES; k >= 1; k--) begin
      ii = PW'((int'(cur) + k) % N_PHASES);
      if (c[ii]) pick = ii;
    end
    return pick;
  endfunction

`ifdef TLC_PREEMPT_EN
  // This register remembers the preemption target across YELLOW and ALLRED.
  // The target is then served even if pre_req has dropped by that time.
  logic          pre_hold;
  logic [PW-1:0] pre_tgt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_hold <= 1'b0;
      pre_tgt  <= '0;
    end else if (grant) begin
      pre_hold <= 1'b0;
    end else if (state == GREEN && pre_req && pre_phase != cur_phase) begin
      pre_hold <= 1'b1;
      pre_tgt  <= pre_phase;
    end
  end
`endif

  always_comb begin
    own_mask   = ONE_N << cur_phase;
    cand       = pending | req;
    win        = rr_pick(cand, cur_phase);
    other      = |(pending & ~own_mask);
    green_exit = (green_ctr >= MIN_C) &&
                 ((other && (green_ctr >= MAX_C)) || (gap_ctr >= GAP_C));
`ifdef TLC_PREEMPT_EN
    // Preemption overrides all green timing. A foreign target forces an exit.
    // The target's own green holds.
    if (pre_req) green_exit = (pre_phase != cur_phase);
`endif
    nstate = state;
    grant  = 1'b0;
    gphase = cur_phase;
    case (state)
      IDLE: begin
`ifdef TLC_PREEMPT_EN
        if (pre_req) begin
          grant  = 1'b1;
          gphase = pre_phase;
        end else
`endif
        if (|cand) begin
          grant  = 1'b1;
          gphase = win;
        end
      end
      GREEN:    if (green_exit) nstate = YELLOW_S;
      YELLOW_S: if (tmr >= YEL_C) nstate = ALLRED_S;
      ALLRED_S: begin
        if (tmr >= AR_C) begin
`ifdef TLC_PREEMPT_EN
          if (pre_hold) begin
            grant  = 1'b1;
            gphase = pre_tgt;
          end else
`endif
          if (|cand) begin
            grant  = 1'b1;
            gphase = win;
          end else begin
            nstate = IDLE;
          end
        end
      end
      default: nstate = IDLE;
    endcase
    if (grant) nstate = GREEN;
    // The phase that is currently green does not latch its own request.
    set_mask = (state == GREEN) ? (req & ~own_mask) : req;
    clr_mask = grant ? (ONE_N << gphase) : '0;
    nmask    = ONE_N << gphase;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      green_ctr <= '0;
      gap_ctr   <= '0;
      tmr       <= '0;
      cur_phase <= PW'(N_PHASES - 1);
      green     <= '0;
      yellow    <= '0;
      busy      <= 1'b0;
    end else begin
      state   <= nstate;
      pending <= (pending | set_mask) & ~clr_mask;   // clear beats set
      if (grant) begin
        cur_phase <= gphase;
        green_ctr <= ONE_C;
        gap_ctr   <= '0;
      end else if (state == GREEN) begin
        if (green_ctr < MAX_C) green_ctr <= green_ctr + ONE_C;
        if (req[cur_phase])    gap_ctr   <= '0;
        else if (gap_ctr < GAP_C) gap_ctr <= gap_ctr + ONE_C;
      end
      // tmr counts 1..YELLOW and 1..ALLRED. It restarts on every state change.
      if (nstate != state)                            tmr <= ONE_C;
      else if (state == YELLOW_S || state == ALLRED_S) tmr <= tmr + ONE_C;
      green  <= (nstate == GREEN)    ? nmask : '0;
      yellow <= (nstate == YELLOW_S) ? nmask : '0;
      busy   <= (nstate != IDLE);
    end
  end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Testbench for tlc_phase_scheduler (default build).
// The bench keeps a behavioural model of the intersection. The model tracks
// the mode, the age of the current green, the run of quiet own-sensor cycles
// and a pending set. It advances on each clock edge, using the request that
// the DUT saw. A compare process checks the lamps, busy and cur_phase against
// the model on every falling edge. Directed scenarios add literal
// expectations: lamp durations, grant order, and state after reset.
module tb_tlc_phase_scheduler;
  localparam int N     = 5;
  localparam int MIN_G = 3;
  localparam int MAX_G = 10;
  localparam int GAP_N = 5;
  localparam int YEL_N = 2;
  localparam int AR_N  = 1;
  localparam int M_IDLE = 0, M_GREEN = 1, M_YEL = 2, M_AR = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] green, yellow;
  logic [2:0]   cur_phase;
  logic         busy;
`ifdef TLC_PREEMPT_EN
  logic         pre_req = 1'b0;
  logic [2:0]   pre_phase = '0;
`endif

  tlc_phase_scheduler #(
    .N_PHASES(N), .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G),
    .GAP(GAP_N), .YELLOW(YEL_N), .ALLRED(AR_N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
`ifdef TLC_PREEMPT_EN
    .pre_req(pre_req),
    .pre_phase(pre_phase),
`endif
    .green(green),
    .yellow(yellow),
    .cur_phase(cur_phase),
    .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cnt_g[N];
  int cnt_y[N];
  int cnt_ar;
  int glog[$];
  logic [N-1:0] prev_g;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_mode, m_cur, m_age, m_quiet, m_tin;
  logic [N-1:0] m_pend;

  function automatic int rr_first(input logic [N-1:0] c, input int cur);
    for (int k = 1; k <= N; k++) begin
      if (c[(cur + k) % N]) return (cur + k) % N;
    end
    return cur;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_cur   = N - 1;
    m_age   = 0;
    m_quiet = 0;
    m_tin   = 0;
    m_pend  = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    logic [N-1:0] cand, nxt, others;
    int w;
    bit granted;
    cand    = m_pend | r;
    nxt     = m_pend;
    granted = 1'b0;
    w       = m_cur;
    for (int i = 0; i < N; i++)
      if (r[i] && !(m_mode == M_GREEN && m_cur == i)) nxt[i] = 1'b1;
    case (m_mode)
      M_IDLE: if (cand != 0) begin granted = 1'b1; w = rr_first(cand, m_cur); end
      M_GREEN: begin
        others = m_pend;
        others[m_cur] = 1'b0;
        if (m_age >= MIN_G && ((others != 0 && m_age >= MAX_G) || m_quiet >= GAP_N)) begin
          m_mode = M_YEL;
          m_tin  = 1;
        end else begin
          m_age++;
          m_quiet = r[m_cur] ? 0 : m_quiet + 1;
        end
      end
      M_YEL: begin
        if (m_tin >= YEL_N) begin m_mode = M_AR; m_tin = 1; end
        else m_tin++;
      end
      default: begin
        if (m_tin >= AR_N) begin
          if (cand != 0) begin granted = 1'b1; w = rr_first(cand, m_cur); end
          else m_mode = M_IDLE;
        end else m_tin++;
      end
    endcase
    if (granted) begin
      m_mode  = M_GREEN;
      m_cur   = w;
      m_age   = 1;
      m_quiet = 0;
      nxt[w]  = 1'b0;
    end
    m_pend = nxt;
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [N-1:0] eg, ey;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        eg = (m_mode == M_GREEN) ? (N'(1) << m_cur) : '0;
        ey = (m_mode == M_YEL)   ? (N'(1) << m_cur) : '0;
        check("green", int'(green), int'(eg));
        check("yellow", int'(yellow), int'(ey));
        check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
        check("cur_phase", int'(cur_phase), m_cur);
        for (int i = 0; i < N; i++) begin
          if (green[i])  cnt_g[i]++;
          if (yellow[i]) cnt_y[i]++;
          if (green[i] && green != prev_g) glog.push_back(i);
        end
        if (busy && green == 0 && yellow == 0) cnt_ar++;
        prev_g = green;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(r);
    #1;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin cnt_g[i] = 0; cnt_y[i] = 0; end
    cnt_ar = 0;
    glog.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    cycle('0);
    cycle('0);
    reset = 1'b1;
    clear_stats();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #2;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    cycle('0);
    cycle('0);
    reset = 1'b1;
    clear_stats();

    // Reset state
    check("rst_green", int'(green), 0);
    check("rst_yellow", int'(yellow), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_phase", int'(cur_phase), 4);

    // Single pulse on phase 2: gap-out after GAP+1 green cycles
    cycle(5'b00100);
    for (int i = 0; i < 12; i++) cycle('0);
    check("pulse_green_len", cnt_g[2], 6);
    check("pulse_yellow_len", cnt_y[2], 2);
    check("pulse_allred_len", cnt_ar, 1);
    check("pulse_idle_busy", int'(busy), 0);
    check("pulse_idle_cur", int'(cur_phase), 2);

    // Phase 0 held and phase 3 waiting: the green of phase 0 ends at MAX_GREEN
    do_reset();
    cycle(5'b00001);
    cycle(5'b00001);
    for (int i = 0; i < 12; i++) cycle(5'b01001);
    check("max_green_len", cnt_g[0], 10);
    check("max_yellow_len", cnt_y[0], 2);
    check("max_allred_len", cnt_ar, 1);
    check("max_next_green", int'(green), 32'h08);
    check("max_next_cur", int'(cur_phase), 3);

    // Phases 1 and 3 at once, then phase 0 during green 3 (order wraps round)
    do_reset();
    cycle(5'b01010);
    for (int i = 0; i < 9; i++) cycle('0);
    cycle(5'b00001);
    for (int i = 0; i < 20; i++) cycle('0);
    check("rr_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      check("rr_first", glog[0], 1);
      check("rr_second", glog[1], 3);
      check("rr_third_wrap", glog[2], 0);
    end

    // Sole demand with steady own traffic: green holds
    do_reset();
    for (int i = 0; i < 52; i++) cycle(5'b10000);
    check("hold_green_len", cnt_g[4], 51);
    check("hold_no_yellow", cnt_y[4], 0);
    check("hold_green", int'(green), 32'h10);

    // Asynchronous reset in the middle of YELLOW
    do_reset();
    cycle(5'b00100);
    for (int i = 0; i < 7; i++) cycle('0);
    check("ayr_in_yellow", int'(yellow), 32'h04);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("ayr_green_off", int'(green), 0);
    check("ayr_yellow_off", int'(yellow), 0);
    check("ayr_busy_off", int'(busy), 0);
    check("ayr_cur_phase", int'(cur_phase), 4);
    cycle('0);
    reset = 1'b1;
    cycle(5'b00010);
    check("ayr_regrant", int'(green), 32'h02);
    check("ayr_regrant_cur", int'(cur_phase), 1);
    for (int i = 0; i < 12; i++) cycle('0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
- Round-robin phase scheduler for an N-phase intersection. Exactly one phase holds the right-of-way at a time; phases are mutually exclusive.
- Latches sensor requests and grants green by round-robin from the last-served phase.
- Enforces min-green, max-green, gap-out, yellow and all-red timing.
- Drives per-phase green/yellow lines. The light-decode layer maps each phase to its street lamps.

Parameters:
N_PHASES, 5, number of mutually exclusive phases (2..8)
MIN_GREEN, 3, minimum green cycles before any exit
MAX_GREEN, 10, green cycle limit while another phase is pending (must be >= MIN_GREEN)
GAP, 5, consecutive own-sensor-low cycles that end green (gap-out)
YELLOW, 2, yellow cycles
ALLRED, 1, all-red clearance cycles after yellow

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req  in  N_PHASES  raw phase sensors, one bit per phase
green  out  N_PHASES  one-hot or zero; green lamp per phase
yellow  out  N_PHASES  one-hot or zero; yellow lamp per phase
cur_phase  out  $clog2(N_PHASES)  phase currently or last served
busy  out  1  high in GREEN, YELLOW, ALLRED

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, pending=0, counters=0, cur_phase=N_PHASES-1, so phase 0 has first priority.
  - All outputs 0.
- Outputs are a Moore decode of registered state and cur_phase:
  - green[cur_phase]=1 only in GREEN.
  - yellow[cur_phase]=1 only in YELLOW.
  - All zero in IDLE and ALLRED.
- Pending latch, per phase i:
  - Set at the edge when req[i]=1, unless state==GREEN && cur_phase==i.
  - Cleared at the edge that enters GREEN for phase i. Clear beats set.
- Candidate vector: cand = pending | req. The round-robin winner is the first set bit of cand searching cur_phase+1, cur_phase+2, … mod N_PHASES; cur_phase itself is searched last.
- IDLE:
  - If cand!=0: next=GREEN, cur_phase=winner, green_ctr=1, gap_ctr=0.
  - Latency: req high before edge k gives green visible after edge k.
- GREEN:
  - green_ctr increments each cycle, saturating at MAX_GREEN.
  - gap_ctr increments when req[cur_phase]=0, saturating at GAP; it clears to 0 when req[cur_phase]=1.
  - other = pending with bit cur_phase masked off is nonzero.
  - Exit to YELLOW when green_ctr>=MIN_GREEN && ((other && green_ctr>=MAX_GREEN) || gap_ctr>=GAP). Otherwise remain in GREEN.
  - With no other demand and own traffic present, green holds indefinitely.
- YELLOW: tmr counts 1..YELLOW, then ALLRED.
- ALLRED:
  - tmr counts 1..ALLRED.
  - Then: if cand!=0, GREEN with the round-robin winner (the same phase may be re-granted only if it is the sole candidate); otherwise IDLE.
- Widths: counters sized $clog2(max(MAX_GREEN,GAP,YELLOW,ALLRED)+1). Counters never wrap.
- Simultaneous events:
  - Multiple new requests in one cycle resolve by round-robin order.
  - A request for the current green phase during GREEN is not latched; it only resets gap_ctr.
- Reset mid-operation: immediate all-off; pending requests are lost.

Optional Feature:
- Macro: TLC_PREEMPT_EN.
- When defined, adds ports pre_req (in, 1) and pre_phase (in, $clog2(N_PHASES)).
- pre_req=1 in GREEN with cur_phase!=pre_phase:
  - Exit to YELLOW at the next edge, ignoring MIN_GREEN.
  - After ALLRED, grant pre_phase regardless of round-robin order.
- pre_req=1 in GREEN with cur_phase==pre_phase: green holds, ignoring MAX_GREEN and gap.
- pre_req=1 in IDLE: grant pre_phase immediately.
- Pending bits are unaffected by preemption.
- Without the macro: ports absent; behaviour exactly as above.

Test Plan:
- Reset, then req[2] pulsed for 1 cycle -> green[2] high for exactly 6 cycles (GAP+1), yellow[2] for 2, all-off for 1, then IDLE with busy=0 and cur_phase=2.
- req[0] held high, req[3] asserted at green cycle 2 -> green[0] for exactly 10 cycles (MAX_GREEN), yellow 2, all-red 1, then green[3].
- From reset, req[1] and req[3] asserted in the same cycle -> green[1] first, then green[3]. req[0] pulsed during green[3] -> green[0] served next (wrap).
- req[4] held high, no other requests for 50 cycles -> green[4] stays high throughout, yellow never asserts.
- reset driven low mid-YELLOW, asynchronously between clock edges -> outputs 0 immediately. After release, req[1] -> green[1] next edge (phase 0 not pending).
- TLC_PREEMPT_EN: green[0] at cycle 1, pre_req=1 with pre_phase=2 -> yellow[0] the next cycle, then 2 yellow, 1 all-red, then green[2], held while pre_req=1 past 10 cycles.
